// File: rtl/hub75_shifter_if.sv
// hub75_shifter_if: request, frame-buffer and HUB75 pin bundle for hub75_shifter
interface hub75_shifter_if #(
  parameter int hpixel_p = 64,
  parameter int vpixel_p = 64,
  parameter int bpp_p = 8,
  parameter int segments_p = 2
);
  localparam int out_rows_p = vpixel_p / segments_p;
  localparam int rw = out_rows_p > 1 ? $clog2(out_rows_p) : 1;
  localparam int bw = bpp_p > 1 ? $clog2(bpp_p) : 1;
  localparam int aw = out_rows_p * hpixel_p > 1 ? $clog2(out_rows_p * hpixel_p) : 1;
  logic i_valid;
  logic o_ready;
  logic [rw-1:0] i_row;
  logic [bw-1:0] i_pix_bit;
  logic o_done;
  logic o_mem_rd_en;
  logic [aw-1:0] o_mem_addr;
  logic [segments_p*3*bpp_p-1:0] i_mem_rdata;
  logic [3*segments_p-1:0] o_hub_rgb;
  logic o_hub_clk;
  logic o_hub_lat;
  modport slave (
    input i_valid, i_row, i_pix_bit, i_mem_rdata,
    output o_ready, o_done, o_mem_rd_en, o_mem_addr, o_hub_rgb, o_hub_clk, o_hub_lat
  );
  modport master (
    output i_valid, i_row, i_pix_bit, i_mem_rdata,
    input o_ready, o_done, o_mem_rd_en, o_mem_addr, o_hub_rgb, o_hub_clk, o_hub_lat
  );
endinterface

// File: rtl/hub75_shifter.sv
// hub75_shifter: streams one bit plane of one panel row onto the HUB75 RGB/CLK lines, then pulses LAT
module hub75_shifter #(
  parameter int hpixel_p = 64,
  parameter int vpixel_p = 64,
  parameter int bpp_p = 8,
  parameter int segments_p = 2,
  parameter int clk_div_p = 2
) (
  input logic clk,
  input logic rst,
  hub75_shifter_if.slave bus
);
  localparam int out_rows_p = vpixel_p / segments_p;
  localparam int rw = out_rows_p > 1 ? $clog2(out_rows_p) : 1;
  localparam int bw = bpp_p > 1 ? $clog2(bpp_p) : 1;
  localparam int cw = hpixel_p > 1 ? $clog2(hpixel_p) : 1;
  localparam int aw = out_rows_p * hpixel_p > 1 ? $clog2(out_rows_p * hpixel_p) : 1;
  localparam int dw = clk_div_p > 1 ? $clog2(clk_div_p) : 1;
  localparam int nch = 3 * segments_p;
  typedef enum logic [2:0] {IDLE, READ, WAIT, CLK_LO, CLK_HI, LATCH, DONE} state_t;
  state_t state_q, state_d;
  logic [cw-1:0] col_q, col_d;
  logic [rw-1:0] row_q, row_d;
  logic [bw-1:0] pix_q, pix_d;
  logic [dw-1:0] div_q, div_d;
  logic [aw-1:0] addr_q, addr_d;
  logic [nch-1:0] rgb_q, rgb_d;
  logic last_div, last_col;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q <= '0;
      row_q <= '0;
      pix_q <= '0;
      div_q <= '0;
      addr_q <= '0;
      rgb_q <= '0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      pix_q <= pix_d;
      div_q <= div_d;
      addr_q <= addr_d;
      rgb_q <= rgb_d;
    end
  end
  always_comb begin
    last_div = div_q == dw'(clk_div_p - 1);
    last_col = col_q == cw'(hpixel_p - 1);
    state_d = state_q;
    col_d = col_q;
    row_d = row_q;
    pix_d = pix_q;
    div_d = (state_q inside {CLK_LO, CLK_HI, LATCH}) && !last_div ? div_q + 1'b1 : '0;
    case (state_q)
      IDLE: if (bus.i_valid) begin
        state_d = READ;
        row_d = bus.i_row;
        pix_d = bus.i_pix_bit;
        col_d = '0;
      end
      READ: state_d = WAIT;
      WAIT: state_d = CLK_LO;
      CLK_LO: state_d = last_div ? CLK_HI : CLK_LO;
      CLK_HI: if (last_div) begin
        state_d = last_col ? LATCH : READ;
        col_d = last_col ? col_q : col_q + 1'b1;
      end
      LATCH: state_d = last_div ? DONE : LATCH;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // address is computed at full width so the last row never wraps
    addr_d = state_d == READ ? aw'(row_d) * aw'(hpixel_p) + aw'(col_d) : addr_q;
    rgb_d = rgb_q;
    for (int j = 0; j < nch; j++)
      if (state_q == WAIT) rgb_d[j] = |(bus.i_mem_rdata[j*bpp_p +: bpp_p] & (bpp_p'(1) << pix_q));
  end
  always_comb begin
    bus.o_ready = state_q == IDLE;
    bus.o_mem_rd_en = state_q == READ;
    bus.o_hub_clk = state_q == CLK_HI;
    bus.o_hub_lat = state_q == LATCH;
    bus.o_done = state_q == DONE;
    bus.o_mem_addr = addr_q;
    bus.o_hub_rgb = rgb_q;
  end
endmodule

// File: tb/tb_hub75_shifter.sv
// tb_hub75_shifter: directed/random row streams on two instances (clk_div 2 and 1) against a frame-buffer model
module tb_hub75_shifter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  hub75_shifter_if b0 ();
  hub75_shifter_if b1 ();
  hub75_shifter d0 (.clk(clk), .rst(rst), .bus(b0));
  hub75_shifter #(.clk_div_p(1)) d1 (.clk(clk), .rst(rst), .bus(b1));
  logic [1:0] v;
  logic [4:0] row_i;
  logic [2:0] pb_i;
  logic [1:0] rd_en, hclk, lat, done, rdy;
  logic [10:0] addr [2];
  logic [5:0] rgb [2];
  logic [47:0] mem [2048];
  int checks = 0;
  int errors = 0;
  assign b0.i_valid = v[0];
  assign b1.i_valid = v[1];
  assign b0.i_row = row_i;
  assign b1.i_row = row_i;
  assign b0.i_pix_bit = pb_i;
  assign b1.i_pix_bit = pb_i;
  assign rd_en = {b1.o_mem_rd_en, b0.o_mem_rd_en};
  assign hclk = {b1.o_hub_clk, b0.o_hub_clk};
  assign lat = {b1.o_hub_lat, b0.o_hub_lat};
  assign done = {b1.o_done, b0.o_done};
  assign rdy = {b1.o_ready, b0.o_ready};
  assign addr[0] = b0.o_mem_addr;
  assign addr[1] = b1.o_mem_addr;
  assign rgb[0] = b0.o_hub_rgb;
  assign rgb[1] = b1.o_hub_rgb;
  always @(posedge clk) begin
    b0.i_mem_rdata <= rd_en[0] ? mem[addr[0]] : 48'({$urandom, $urandom});
    b1.i_mem_rdata <= rd_en[1] ? mem[addr[1]] : 48'({$urandom, $urandom});
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [5:0] exp_rgb(int row, int pb, int k);
    logic [47:0] w;
    logic [5:0] r;
    w = mem[row*64 + k];
    for (int j = 0; j < 6; j++) r[j] = pb < 8 ? w[j*8 + pb] : 1'b0;
    return r;
  endfunction
  for (genvar g = 0; g < 2; g++) begin : g_prot
    logic [5:0] prgb = '0;
    logic prd = 1'b0;
    always @(negedge clk) begin
      if (!rst) begin
        if (hclk[g]) chk("rgb_stable_clk_hi", rgb[g], prgb);
        if (lat[g]) chk("lat_clk_overlap", hclk[g], 0);
        if (rd_en[g]) chk("rd_single_pulse", prd, 0);
      end
      prgb = rgb[g];
      prd = rd_en[g];
    end
  end
  // call at a negedge; returns at the negedge where o_ready is expected back
  task automatic run_row(input int d, input int row, input int pb, input bit hold, input int abort);
    int cd, cl, dl, latn, latf, donel;
    logic pclk;
    logic [10:0] addrs [$];
    logic [5:0] rgbs [$];
    cd = d ? 1 : 2;
    cl = 2 + 2*cd;
    dl = 64*cl + cd + 1;
    latn = 0;
    latf = 0;
    donel = 0;
    pclk = 1'b0;
    row_i = 5'(row);
    pb_i = 3'(pb);
    v[d] = 1'b1;
    chk("accept_ready", rdy[d], 1);
    for (int l = 1; l <= dl + 1; l++) begin
      @(negedge clk);
      if (l == 1 && !hold) v[d] = 1'b0;
      if (hold) begin
        row_i = 5'($urandom);
        pb_i = 3'($urandom);
      end
      if (abort != 0 && l == abort) begin
        chk("abort_in_clk_hi", hclk[d], 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outs_zero", {rd_en[d], addr[d], rgb[d], hclk[d], lat[d], done[d]}, 0);
        chk("abort_ready", rdy[d], 1);
        rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
          @(negedge clk);
          if (lat[d]) latn++;
          if (done[d]) donel++;
        end
        chk("abort_no_lat", latn, 0);
        chk("abort_no_done", donel, 0);
        return;
      end
      if (rd_en[d]) addrs.push_back(addr[d]);
      if (hclk[d] && !pclk) rgbs.push_back(rgb[d]);
      pclk = hclk[d];
      if (lat[d]) begin
        latn++;
        if (latf == 0) latf = l;
      end
      if (done[d] && donel == 0) donel = l;
      if (l == 1) chk("busy_not_ready", rdy[d], 0);
      if (l == dl + 1) chk("ready_after_done", rdy[d], 1);
    end
    chk("read_count", addrs.size(), 64);
    for (int k = 0; k < 64 && k < addrs.size(); k++) chk("read_addr", addrs[k], row*64 + k);
    chk("clk_rises", rgbs.size(), 64);
    for (int k = 0; k < 64 && k < rgbs.size(); k++) chk("rgb_at_rise", rgbs[k], exp_rgb(row, pb, k));
    chk("lat_cycles", latn, cd);
    chk("lat_start", latf, 64*cl + 1);
    chk("done_cycle", donel, dl);
  endtask
  initial begin
    v = '0;
    row_i = '0;
    pb_i = '0;
    for (int i = 0; i < 2048; i++) mem[i] = 48'({$urandom, $urandom});
    for (int k = 0; k < 64; k++) mem[320 + k][0] = k[0];
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_outs_zero", {rd_en[d], addr[d], rgb[d], hclk[d], lat[d], done[d]}, 0);
      chk("reset_ready", rdy[d], 1);
    end
    rst = 1'b0;
    @(negedge clk);
    run_row(0, 5, 0, 1'b0, 0);
    for (int k = 0; k < 64; k++) mem[448 + k] = 48'h81 << 32;
    for (int pb = 0; pb < 8; pb++) run_row(0, 7, pb, 1'b0, 0);
    run_row(0, 12, 5, 1'b1, 0);
    run_row(0, 20, 2, 1'b1, 0);
    run_row(0, 9, 6, 1'b0, 0);
    run_row(0, 9, 3, 1'b0, 185);
    run_row(0, 9, 3, 1'b0, 0);
    run_row(0, 31, int'($urandom_range(7, 0)), 1'b0, 0);
    run_row(1, 31, int'($urandom_range(7, 0)), 1'b0, 0);
    run_row(1, 5, 0, 1'b0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
